// File: rtl/event_scheduler3.sv
// Event scheduler: writes pixel events into a 256x256 feature map, queues the 3x3 neighbourhood
// centres of each event, and replays each queued centre as a packed 3x3 window.
module event_scheduler3 #(
    parameter int DATA_WIDTH             = 4,
    parameter int TODO_WINDOW_FIFO_DEPTH = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   in_event_value,
    input  logic [15:0]             in_event_addr,
    input  logic                    in_event_valid,
    output logic                    ready_for_new_event,
    input  logic                    window_req,
    output logic [9*DATA_WIDTH-1:0] out_window_value,
    output logic [15:0]             out_window_addr,
    output logic                    out_window_valid
);

    localparam int FD = TODO_WINDOW_FIFO_DEPTH;
    localparam int FA = (FD > 1) ? $clog2(FD) : 1;
    localparam int CW = $clog2(FD + 1);

    typedef enum logic {IN_IDLE, IN_PUSH} in_state_t;
    typedef enum logic [1:0] {G_IDLE, G_READ, G_LAST} g_state_t;

    // Neighbour k of centre c as {in_range, row, col}; k = (dr+1)*3 + (dc+1).
    function automatic logic [16:0] nbr(input logic [15:0] c, input logic [3:0] k);
        logic [1:0] kr;
        logic [1:0] kc;
        logic [7:0] r;
        logic [7:0] col;
        logic       ok;
        case (k)
            4'd0:    begin kr = 2'd0; kc = 2'd0; end
            4'd1:    begin kr = 2'd0; kc = 2'd1; end
            4'd2:    begin kr = 2'd0; kc = 2'd2; end
            4'd3:    begin kr = 2'd1; kc = 2'd0; end
            4'd4:    begin kr = 2'd1; kc = 2'd1; end
            4'd5:    begin kr = 2'd1; kc = 2'd2; end
            4'd6:    begin kr = 2'd2; kc = 2'd0; end
            4'd7:    begin kr = 2'd2; kc = 2'd1; end
            default: begin kr = 2'd2; kc = 2'd2; end
        endcase
        ok  = 1'b1;
        r   = c[15:8];
        col = c[7:0];
        if (kr == 2'd0) begin
            ok = ok & (r != 8'd0);
            r  = r - 8'd1;
        end else if (kr == 2'd2) begin
            ok = ok & (r != 8'hFF);
            r  = r + 8'd1;
        end
        if (kc == 2'd0) begin
            ok  = ok & (col != 8'd0);
            col = col - 8'd1;
        end else if (kc == 2'd2) begin
            ok  = ok & (col != 8'hFF);
            col = col + 8'd1;
        end
        return {ok, r, col};
    endfunction

    in_state_t              in_state_q, in_state_d;
    logic [3:0]             in_k_q, in_k_d;
    logic [15:0]            ev_addr_q, ev_addr_d;
    g_state_t               g_state_q, g_state_d;
    logic [3:0]             g_k_q, g_k_d;
    logic [15:0]            g_centre_q, g_centre_d;
    logic [FA-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d, fifo_free;
    logic                   slot_vld_q, slot_ok_q;
    logic [3:0]             slot_k_q;
    logic [9*DATA_WIDTH-1:0] win_acc_q, win_next, out_value_q, out_value_d;
    logic [15:0]            out_addr_q, out_addr_d;
    logic                   out_valid_q, out_valid_d;

    logic [DATA_WIDTH-1:0]  map_mem [0:65535];
    logic [DATA_WIDTH-1:0]  rd_data_q;
    logic [15:0]            fifo_mem [FD];
    logic [15:0]            fifo_head;

    logic                   accept, push, pop, rd_en, emit;
    logic [16:0]            push_nbr, rd_nbr;
    logic [DATA_WIDTH-1:0]  slot_data;

    assign fifo_free           = CW'(FD) - count_q;
    assign ready_for_new_event = rst_n && (in_state_q == IN_IDLE) && (fifo_free >= CW'(9));
    assign accept              = in_event_valid && ready_for_new_event;
    assign push_nbr            = nbr(ev_addr_q, in_k_q);
    assign push                = (in_state_q == IN_PUSH) && push_nbr[16];
    assign pop                 = (g_state_q == G_IDLE) && (count_q != '0) && window_req;
    assign fifo_head           = fifo_mem[rd_ptr_q];
    assign rd_nbr              = nbr(g_centre_q, g_k_q);
    assign rd_en               = (g_state_q == G_READ) && rd_nbr[16];

    // Map and FIFO storage carry no reset so they map onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            map_mem[in_event_addr] <= in_event_value;
        end
        if (rd_en) begin
            rd_data_q <= map_mem[rd_nbr[15:0]];
        end
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_nbr[15:0];
        end
    end

    always_comb begin
        in_state_d = in_state_q;
        in_k_d     = in_k_q;
        ev_addr_d  = ev_addr_q;
        case (in_state_q)
            IN_IDLE: begin
                if (accept) begin
                    in_state_d = IN_PUSH;
                    in_k_d     = 4'd0;
                    ev_addr_d  = in_event_addr;
                end
            end
            IN_PUSH: begin
                if (in_k_q == 4'd8) begin
                    in_state_d = IN_IDLE;
                end else begin
                    in_k_d = in_k_q + 4'd1;
                end
            end
            default: in_state_d = IN_IDLE;
        endcase
    end

    always_comb begin
        g_state_d  = g_state_q;
        g_k_d      = g_k_q;
        g_centre_d = g_centre_q;
        case (g_state_q)
            G_IDLE: begin
                if (pop) begin
                    g_state_d  = G_READ;
                    g_k_d      = 4'd0;
                    g_centre_d = fifo_head;
                end
            end
            G_READ: begin
                if (g_k_q == 4'd8) begin
                    g_state_d = G_LAST;
                end else begin
                    g_k_d = g_k_q + 4'd1;
                end
            end
            G_LAST:  g_state_d = G_IDLE;
            default: g_state_d = G_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == FA'(FD - 1)) ? '0 : wr_ptr_q + FA'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == FA'(FD - 1)) ? '0 : rd_ptr_q + FA'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Read data lands one cycle after issue; skipped reads contribute zero.
    assign slot_data = slot_ok_q ? rd_data_q : '0;
    assign emit      = slot_vld_q && (slot_k_q == 4'd8);

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_slot
            assign win_next[gi*DATA_WIDTH +: DATA_WIDTH] =
                (slot_vld_q && (slot_k_q == 4'(gi))) ? slot_data
                                                     : win_acc_q[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    always_comb begin
        out_valid_d = emit;
        out_value_d = emit ? win_next : out_value_q;
        out_addr_d  = emit ? g_centre_q : out_addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_state_q  <= IN_IDLE;
            in_k_q      <= '0;
            ev_addr_q   <= '0;
            g_state_q   <= G_IDLE;
            g_k_q       <= '0;
            g_centre_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            slot_vld_q  <= 1'b0;
            slot_ok_q   <= 1'b0;
            slot_k_q    <= '0;
            win_acc_q   <= '0;
            out_value_q <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            in_state_q  <= in_state_d;
            in_k_q      <= in_k_d;
            ev_addr_q   <= ev_addr_d;
            g_state_q   <= g_state_d;
            g_k_q       <= g_k_d;
            g_centre_q  <= g_centre_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            slot_vld_q  <= (g_state_q == G_READ);
            slot_ok_q   <= rd_en;
            slot_k_q    <= g_k_q;
            win_acc_q   <= win_next;
            out_value_q <= out_value_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_window_value = out_value_q;
    assign out_window_addr  = out_addr_q;
    assign out_window_valid = out_valid_q;

endmodule

// File: tb/tb_event_scheduler3.sv
// Directed self-checking bench for event_scheduler3: window order, packing, latency,
// edge clipping, FIFO back-pressure, overwrite and mid-operation reset.
module tb_event_scheduler3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  in_event_value = '0;
    logic [15:0] in_event_addr = '0;
    logic        in_event_valid = 1'b0;
    logic        ready_for_new_event;
    logic        window_req = 1'b0;
    logic [35:0] out_window_value;
    logic [15:0] out_window_addr;
    logic        out_window_valid;

    int compared = 0;
    int mismatched = 0;

    event_scheduler3 #(.DATA_WIDTH(4), .TODO_WINDOW_FIFO_DEPTH(256)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_event_value      (in_event_value),
        .in_event_addr       (in_event_addr),
        .in_event_valid      (in_event_valid),
        .ready_for_new_event (ready_for_new_event),
        .window_req          (window_req),
        .out_window_value    (out_window_value),
        .out_window_addr     (out_window_addr),
        .out_window_valid    (out_window_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] mon_addr[$];
    logic [35:0] mon_val[$];
    int          mon_cyc[$];
    int          acc_cnt = 0;

    always @(negedge clk) begin
        if (out_window_valid) begin
            mon_addr.push_back(out_window_addr);
            mon_val.push_back(out_window_value);
            mon_cyc.push_back(cyc);
            $display("window  cyc=%0d addr=%h value=%h", cyc, out_window_addr, out_window_value);
        end
        if (in_event_valid && ready_for_new_event) begin
            acc_cnt++;
            $display("accept  cyc=%0d addr=%h value=%0d", cyc, in_event_addr, in_event_value);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic send_event(input logic [15:0] a, input logic [3:0] v);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        in_event_addr  = a;
        in_event_value = v;
        in_event_valid = 1'b1;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            if (ready_for_new_event) ok = 1'b1;
        end
        @(posedge clk); #1;
        in_event_valid = 1'b0;
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL send_event_timeout addr=%h got ready=0 required ready=1", a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared++;
        if (ready_for_new_event !== 1'b0) begin
            mismatched++; $display("FAIL reset_ready got %b required 0", ready_for_new_event);
        end
        compared++;
        if (out_window_valid !== 1'b0) begin
            mismatched++; $display("FAIL reset_valid got %b required 0", out_window_valid);
        end
        compared++;
        if (out_window_value !== 36'h0) begin
            mismatched++; $display("FAIL reset_value got %h required 0", out_window_value);
        end
        compared++;
        if (out_window_addr !== 16'h0) begin
            mismatched++; $display("FAIL reset_addr got %h required 0", out_window_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (ready_for_new_event !== 1'b1) begin
            mismatched++; $display("FAIL ready_after_reset got %b required 1", ready_for_new_event);
        end
    endtask

    task automatic test_corner();
        int          base;
        logic [15:0] ea[4];
        logic [35:0] ev[4];
        ea = '{16'h0000, 16'h0001, 16'h0100, 16'h0101};
        ev = '{36'h0_0003_0000, 36'h0_0000_3000, 36'h0_0000_0030, 36'h0_0000_0003};
        base = mon_addr.size();
        window_req = 1'b1;
        send_event(16'h0000, 4'd3);
        repeat (100) @(posedge clk);
        @(negedge clk);
        compared++;
        if (mon_addr.size() - base != 4) begin
            mismatched++; $display("FAIL corner_count got %0d required 4", mon_addr.size() - base);
        end
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (base + i >= mon_addr.size()) begin
                mismatched++; $display("FAIL corner_missing index %0d required addr %h", i, ea[i]);
            end else if (mon_addr[base+i] !== ea[i] || mon_val[base+i] !== ev[i]) begin
                mismatched++;
                $display("FAIL corner_window %0d got %h/%h required %h/%h",
                         i, mon_addr[base+i], mon_val[base+i], ea[i], ev[i]);
            end
        end
        window_req = 1'b0;
    endtask

    task automatic test_order_latency();
        int          base, c0, k;
        logic [7:0]  r, c;
        logic [35:0] exp_v;
        base = mon_addr.size();
        send_event(16'h0505, 4'd5);
        repeat (12) @(posedge clk);
        @(negedge clk);
        compared++;
        if (mon_addr.size() != base) begin
            mismatched++; $display("FAIL no_req_windows got %0d required 0", mon_addr.size() - base);
        end
        @(posedge clk); #1;
        window_req = 1'b1;
        c0 = cyc;
        repeat (9 * 11 + 20) @(posedge clk);
        @(negedge clk);
        compared++;
        if (mon_addr.size() - base != 9) begin
            mismatched++; $display("FAIL order_count got %0d required 9", mon_addr.size() - base);
        end
        for (int i = 0; i < 9 && base + i < mon_addr.size(); i++) begin
            r = 8'(4 + i / 3);
            c = 8'(4 + i % 3);
            k = (6 - int'(r)) * 3 + (6 - int'(c));
            exp_v = 36'd5 << (4 * k);
            compared++;
            if (mon_addr[base+i] !== {r, c} || mon_val[base+i] !== exp_v) begin
                mismatched++;
                $display("FAIL order_window %0d got %h/%h required %h/%h",
                         i, mon_addr[base+i], mon_val[base+i], {r, c}, exp_v);
            end
            compared++;
            if (mon_cyc[base+i] != ((i == 0) ? c0 + 11 : mon_cyc[base+i-1] + 11)) begin
                mismatched++;
                $display("FAIL strobe_cycle %0d got %0d required %0d", i, mon_cyc[base+i],
                         (i == 0) ? c0 + 11 : mon_cyc[base+i-1] + 11);
            end
        end
        window_req = 1'b0;
    endtask

    task automatic test_overwrite();
        int          base, j, k;
        logic [7:0]  r, c;
        logic [35:0] exp_v;
        base = mon_addr.size();
        send_event(16'h0505, 4'd7);
        send_event(16'h0505, 4'd2);
        repeat (12) @(posedge clk);
        #1 window_req = 1'b1;
        repeat (18 * 11 + 30) @(posedge clk);
        @(negedge clk);
        compared++;
        if (mon_addr.size() - base != 18) begin
            mismatched++; $display("FAIL overwrite_count got %0d required 18", mon_addr.size() - base);
        end
        for (int i = 0; i < 18 && base + i < mon_addr.size(); i++) begin
            j = i % 9;
            r = 8'(4 + j / 3);
            c = 8'(4 + j % 3);
            k = (6 - int'(r)) * 3 + (6 - int'(c));
            exp_v = 36'd2 << (4 * k);
            compared++;
            if (mon_addr[base+i] !== {r, c} || mon_val[base+i] !== exp_v) begin
                mismatched++;
                $display("FAIL overwrite_window %0d got %h/%h required %h/%h",
                         i, mon_addr[base+i], mon_val[base+i], {r, c}, exp_v);
            end
        end
        window_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        int base, a0, ready_seen;
        base = mon_addr.size();
        a0 = acc_cnt;
        for (int i = 0; i < 28; i++) begin
            send_event({8'h40, 8'(16 + 4 * i)}, 4'(i));
        end
        repeat (12) @(posedge clk);
        #1;
        in_event_addr  = 16'h8080;
        in_event_value = 4'd1;
        in_event_valid = 1'b1;
        ready_seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (ready_for_new_event) ready_seen++;
        end
        @(posedge clk); #1;
        in_event_valid = 1'b0;
        compared++;
        if (ready_seen != 0) begin
            mismatched++; $display("FAIL full_ready got %0d ready cycles required 0", ready_seen);
        end
        compared++;
        if (acc_cnt - a0 != 28) begin
            mismatched++; $display("FAIL full_accepts got %0d required 28", acc_cnt - a0);
        end
        compared++;
        if (mon_addr.size() != base) begin
            mismatched++; $display("FAIL full_no_windows got %0d required 0", mon_addr.size() - base);
        end
        window_req = 1'b1;
        repeat (252 * 11 + 60) @(posedge clk);
        @(negedge clk);
        compared++;
        if (mon_addr.size() - base != 252) begin
            mismatched++; $display("FAIL drain_count got %0d required 252", mon_addr.size() - base);
        end
        window_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        int base;
        send_event(16'h0A0A, 4'd9);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        compared++;
        if (out_window_value !== 36'h0 || out_window_addr !== 16'h0 || out_window_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset_outputs got %h/%h/%b required 0/0/0",
                     out_window_value, out_window_addr, out_window_valid);
        end
        compared++;
        if (ready_for_new_event !== 1'b0) begin
            mismatched++; $display("FAIL async_reset_ready got %b required 0", ready_for_new_event);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        window_req = 1'b1;
        base = mon_addr.size();
        repeat (40) @(posedge clk);
        @(negedge clk);
        compared++;
        if (mon_addr.size() != base) begin
            mismatched++; $display("FAIL reset_flush got %0d windows required 0", mon_addr.size() - base);
        end
        send_event(16'h0504, 4'd1);
        repeat (130) @(posedge clk);
        @(negedge clk);
        compared++;
        if (mon_addr.size() - base != 9) begin
            mismatched++; $display("FAIL post_reset_count got %0d required 9", mon_addr.size() - base);
        end else begin
            compared++;
            if (mon_addr[base+4] !== 16'h0504 || mon_val[base+4] !== 36'h0_0021_0000) begin
                mismatched++;
                $display("FAIL post_reset_0504 got %h/%h required 0504/000210000",
                         mon_addr[base+4], mon_val[base+4]);
            end
            compared++;
            if (mon_addr[base+5] !== 16'h0505 || mon_val[base+5] !== 36'h0_0002_1000) begin
                mismatched++;
                $display("FAIL post_reset_0505 got %h/%h required 0505/000021000",
                         mon_addr[base+5], mon_val[base+5]);
            end
        end
        window_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_corner();
        test_order_latency();
        test_overwrite();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
